// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and small helper functions
// used by both the transmit and receive sides of the link.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Ceiling log2, usable in constant expressions for sizing pointers.
    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 32'sd1;
            end
        end
        return r;
    endfunction

    function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-side byte interface and line/status signals of the buffered UART transmitter.
interface uart_tx_fifo_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] DATA_IN;
    logic                   WR_EN;
    logic                   TX;
    logic                   TX_BUSY;
    logic                   FULL;
    logic                   EMPTY;
    logic                   OVF;

    modport master (
        output DATA_IN, WR_EN,
        input  TX, TX_BUSY, FULL, EMPTY, OVF
    );

    modport slave (
        input  DATA_IN, WR_EN,
        output TX, TX_BUSY, FULL, EMPTY, OVF
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Baud-rate divider shared by transmitter and receiver: counts 0..CLKS_PER_BIT-1 and
// flags the terminal count; clear restarts the bit period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] TERM = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt_r;

    assign tick = (cnt_r == TERM);

    // Bit-period counter, wrapping to zero after each tick
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r <= 16'd0;
        end else if (clear || tick) begin
            cnt_r <= 16'd0;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser (8E1 when the
// UART_TX_PARITY_EN macro is defined). Ports are identical in both builds.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_fifo_if.slave bus
);

    localparam int PTR_W = clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [UART_DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic                   ovf_r;

    uart_state_e            state_r;
    uart_state_e            state_next_s;
    logic [UART_DATA_W-1:0] shift_r;
    logic [2:0]             bit_idx_r;
    logic                   tx_r;
    logic                   tx_next_s;
`ifdef UART_TX_PARITY_EN
    logic                   par_r;
`endif

    logic                   full_s;
    logic                   empty_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   ovf_set_s;
    logic                   tick_s;
    logic                   baud_clear_s;
    logic [UART_DATA_W-1:0] head_s;

    assign full_s    = (count_r == CNT_FULL);
    assign empty_s   = (count_r == {CNT_W{1'b0}});
    // A pop frees the head slot this cycle, so a write into a full FIFO is still taken.
    assign push_s    = bus.WR_EN && (!full_s || pop_s);
    assign ovf_set_s = bus.WR_EN && full_s && !pop_s;
    assign head_s    = mem_r[rd_ptr_r];

    assign bus.TX      = tx_r;
    assign bus.TX_BUSY = (state_r != ST_IDLE) || !empty_s;
    assign bus.FULL    = full_s;
    assign bus.EMPTY   = empty_s;
    assign bus.OVF     = ovf_r;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .CLK   (CLK),
        .RST   (RST),
        .clear (baud_clear_s),
        .tick  (tick_s)
    );

    // FIFO storage write port; contents need no reset
    always_ff @(posedge CLK) begin
        if (push_s && !RST) begin
            mem_r[wr_ptr_r] <= bus.DATA_IN;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) state_next_s = ST_START;
                else          state_next_s = ST_IDLE;
            end
            ST_START: begin
                if (tick_s) state_next_s = ST_DATA;
                else        state_next_s = ST_START;
            end
            ST_DATA: begin
                if (tick_s && (bit_idx_r == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_next_s = ST_PARITY;
`else
                    state_next_s = ST_STOP;
`endif
                end else begin
                    state_next_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick_s) state_next_s = ST_STOP;
                else        state_next_s = ST_PARITY;
            end
`endif
            ST_STOP: begin
                if (tick_s && !empty_s)  state_next_s = ST_START;
                else if (tick_s)         state_next_s = ST_IDLE;
                else                     state_next_s = ST_STOP;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: FIFO pop, baud reload and the next line level
    always_comb begin
        pop_s        = 1'b0;
        baud_clear_s = (state_r == ST_IDLE) || (state_next_s != state_r);
        tx_next_s    = 1'b1;
        case (state_r)
            ST_IDLE: begin
                pop_s     = !empty_s;
                tx_next_s = 1'b1;
            end
            ST_START: begin
                tx_next_s = 1'b0;
            end
            ST_DATA: begin
                tx_next_s = shift_r[0];
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_next_s = par_r;
            end
`endif
            ST_STOP: begin
                pop_s     = tick_s && !empty_s;
                tx_next_s = 1'b1;
            end
            default: begin
                pop_s     = 1'b0;
                tx_next_s = 1'b1;
            end
        endcase
    end

    // Shift register and bit index; a pop always starts a fresh frame
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_r   <= {UART_DATA_W{1'b0}};
            bit_idx_r <= 3'd0;
`ifdef UART_TX_PARITY_EN
            par_r     <= 1'b0;
`endif
        end else if (pop_s) begin
            shift_r   <= head_s;
            bit_idx_r <= 3'd0;
`ifdef UART_TX_PARITY_EN
            par_r     <= even_parity(head_s);
`endif
        end else if ((state_r == ST_DATA) && tick_s) begin
            shift_r   <= {1'b0, shift_r[UART_DATA_W-1:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
        end
    end

    // Registered line driver; reset forces the idle level straight away
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_r <= 1'b1;
        end else begin
            tx_r <= tx_next_s;
        end
    end

endmodule
